msg_frame_assembler: RTL

- Upstream stage of the order-processing `top`.
- Collects an 8-bit byte stream (UART/host link side) into one 168-bit order message.
- Presents the message on `msg` and pulses `signal` for exactly one cycle per complete frame.
- Message layout, MSB first: {24b header, 32b field A, 32b price, 32b field C, 8b side, 32b order id, 8b flags}.
- Byte 0 on the wire is msg[167:160].

---
 rtl/msg_frame_assembler.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/msg_frame_assembler.sv
// msg_frame_assembler
// Packs an 8-bit byte stream into one MSG_BYTES-wide order message. Byte 0 on
// the wire ends up in the top byte of msg. A frame whose bytes stop arriving for
// TIMEOUT_CYC cycles is thrown away and counted in drop_cnt.
// Optional feature macro: MSG_FRAME_CHECKSUM_EN. When it is defined, every frame
// carries one extra trailing byte equal to the XOR of the payload bytes, and the
// chk_err port is added.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for the first byte of a frame
// S_COLLECT | payload bytes arriving, idle-gap timer running
// S_CHECK   | (checksum build only) waiting for the trailing XOR byte
// S_EMIT    | one-cycle slot after a good frame; signal high, in_ready low

module msg_frame_assembler #(
   parameter int MSG_BYTES   = 21,
   parameter int TIMEOUT_CYC = 1000,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [8*MSG_BYTES-1:0] msg,
   output logic                   signal,
   output logic [CNT_W-1:0]       frame_cnt,
   output logic [CNT_W-1:0]       drop_cnt
`ifdef MSG_FRAME_CHECKSUM_EN
   ,
   output logic                   chk_err
`endif
);

   localparam int MSG_W = 8 * MSG_BYTES;
   localparam int IDX_W = $clog2(MSG_BYTES + 1);
   localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

`ifdef MSG_FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_CHECK   = 2'd2,
      S_EMIT    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EMIT    = 2'd3
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [MSG_W-1:0]   sreg_q, sreg_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [MSG_W-1:0]   msg_q, msg_d;
   logic               signal_q, signal_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
`ifdef MSG_FRAME_CHECKSUM_EN
   logic [7:0]         chk_q, chk_d;
   logic               chk_err_q, chk_err_d;
`endif

   logic               xfer;
   logic               payload_done;
   logic               idle_tick;
   logic [MSG_W-1:0]   sreg_shift;

   // in_ready depends only on the state register, never on in_valid.
   assign in_ready = (state_q != S_EMIT);
   assign xfer     = in_valid & in_ready;

   if (MSG_BYTES == 1) begin : g_one_byte
      assign sreg_shift = in_data;
   end else begin : g_many_bytes
      assign sreg_shift = {sreg_q[MSG_W-9:0], in_data};
   end

   // Next-state, datapath and counter updates for the frame FSM.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      sreg_d       = sreg_q;
      tmr_d        = tmr_q;
      msg_d        = msg_q;
      signal_d     = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      payload_done = 1'b0;
      idle_tick    = 1'b0;
`ifdef MSG_FRAME_CHECKSUM_EN
      chk_d        = chk_q;
      chk_err_d    = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (xfer) begin
               sreg_d = sreg_shift;
               idx_d  = IDX_W'(1);
`ifdef MSG_FRAME_CHECKSUM_EN
               chk_d  = in_data;
`endif
               if (MSG_BYTES == 1) begin
                  payload_done = 1'b1;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end

         S_COLLECT: begin
            if (xfer) begin
               sreg_d = sreg_shift;
               tmr_d  = '0;
`ifdef MSG_FRAME_CHECKSUM_EN
               chk_d  = chk_q ^ in_data;
`endif
               if (idx_q == LAST_IDX) begin
                  payload_done = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               idle_tick = 1'b1;
            end
         end

`ifdef MSG_FRAME_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               tmr_d  = '0;
               idx_d  = '0;
               sreg_d = '0;
               if (in_data == chk_q) begin
                  msg_d       = sreg_q;
                  signal_d    = 1'b1;
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  state_d     = S_EMIT;
               end else begin
                  drop_cnt_d = drop_cnt_q + 1'b1;
                  chk_err_d  = 1'b1;
                  state_d    = S_IDLE;
               end
            end else begin
               idle_tick = 1'b1;
            end
         end
`endif

         S_EMIT: begin
            tmr_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Last payload byte just shifted in: publish now so msg/signal appear
      // in the very next cycle, or wait for the checksum byte.
      if (payload_done) begin
         idx_d = '0;
         tmr_d = '0;
`ifdef MSG_FRAME_CHECKSUM_EN
         state_d = S_CHECK;
`else
         state_d     = S_EMIT;
         msg_d       = sreg_shift;
         signal_d    = 1'b1;
         frame_cnt_d = frame_cnt_q + 1'b1;
`endif
      end

      // Idle-gap timer; a transfer in the terminal cycle has already cleared it.
      if (idle_tick) begin
         if (tmr_q == TMR_LAST) begin
            sreg_d     = '0;
            idx_d      = '0;
            tmr_d      = '0;
            drop_cnt_d = drop_cnt_q + 1'b1;
            state_d    = S_IDLE;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         sreg_q      <= '0;
         tmr_q       <= '0;
         msg_q       <= '0;
         signal_q    <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
`ifdef MSG_FRAME_CHECKSUM_EN
         chk_q       <= '0;
         chk_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sreg_q      <= sreg_d;
         tmr_q       <= tmr_d;
         msg_q       <= msg_d;
         signal_q    <= signal_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
`ifdef MSG_FRAME_CHECKSUM_EN
         chk_q       <= chk_d;
         chk_err_q   <= chk_err_d;
`endif
      end
   end

   assign msg       = msg_q;
   assign signal    = signal_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`ifdef MSG_FRAME_CHECKSUM_EN
   assign chk_err   = chk_err_q;
`endif

endmodule
